// File: rtl/knockout_sequencer.sv
// SQED knockout window sequencer: counts trig1 edges, arms, waits for trig2,
// then holds a registered knockout enable for KO_LEN cycles.
module knockout_sequencer #(
    parameter int unsigned TRIG1_COUNT = 1,
    parameter int unsigned MAX_GAP     = 16,
    parameter int unsigned KO_LEN      = 1,
    parameter bit          ONESHOT     = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       trig1,
    input  logic       trig2,
    output logic       knockout,
    output logic       fired,
    output logic       timeout,
    output logic [1:0] state,
    output logic [7:0] fire_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRE  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int T1W  = $clog2(TRIG1_COUNT) + 1;
    localparam int GAPW = $clog2(MAX_GAP) + 1;
    localparam int KOW  = $clog2(KO_LEN) + 1;

    localparam logic [T1W-1:0]  T1_LAST  = T1W'(TRIG1_COUNT - 1);
    localparam logic [GAPW-1:0] GAP_LAST = GAPW'(MAX_GAP - 1);
    localparam logic [KOW-1:0]  KO_LAST  = KOW'(KO_LEN - 1);

    state_t          st;
    logic            trig1_q;
    logic            trig2_q;
    logic [T1W-1:0]  t1_cnt;
    logic [GAPW-1:0] gap_cnt;
    logic [KOW-1:0]  ko_cnt;
    logic            ev1;
    logic            ev2;
    logic [7:0]      fire_count_nxt;

    assign ev1   = trig1 & ~trig1_q;
    assign ev2   = trig2 & ~trig2_q;
    assign state = st;

    assign fire_count_nxt = (fire_count == 8'hFF) ? fire_count
                                                  : fire_count + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= IDLE;
            trig1_q    <= 1'b0;
            trig2_q    <= 1'b0;
            t1_cnt     <= '0;
            gap_cnt    <= '0;
            ko_cnt     <= '0;
            knockout   <= 1'b0;
            fired      <= 1'b0;
            timeout    <= 1'b0;
            fire_count <= 8'd0;
        end else begin
            trig1_q <= trig1;
            trig2_q <= trig2;
            timeout <= 1'b0;
            unique case (st)
                IDLE: begin
                    if (!en) begin
                        t1_cnt <= '0;
                    end else if (ev1) begin
                        if (t1_cnt == T1_LAST) begin
                            st      <= ARMED;
                            t1_cnt  <= '0;
                            gap_cnt <= '0;
                        end else begin
                            t1_cnt <= t1_cnt + 1'b1;
                        end
                    end
                end
                ARMED: begin
                    // trig2 beats a simultaneous trig1 and an expiring window
                    if (!en) begin
                        st      <= IDLE;
                        t1_cnt  <= '0;
                        gap_cnt <= '0;
                    end else if (ev2) begin
                        st         <= FIRE;
                        ko_cnt     <= '0;
                        gap_cnt    <= '0;
                        knockout   <= 1'b1;
                        fired      <= 1'b1;
                        fire_count <= fire_count_nxt;
                    end else if (ev1) begin
                        gap_cnt <= '0;
                    end else if (gap_cnt == GAP_LAST) begin
                        st      <= IDLE;
                        gap_cnt <= '0;
                        timeout <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                FIRE: begin
                    if (ko_cnt == KO_LAST) begin
                        st       <= ONESHOT ? DONE : IDLE;
                        ko_cnt   <= '0;
                        knockout <= 1'b0;
                    end else begin
                        ko_cnt <= ko_cnt + 1'b1;
                    end
                end
                DONE: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_knockout_sequencer.sv
// Scoreboard bench: two sequencer configurations share one stimulus stream
// and are compared every cycle against a cycle-level reference model.
module tb_knockout_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       trig1 = 1'b0;
    logic       trig2 = 1'b0;

    logic       ko_a, fired_a, to_a;
    logic [1:0] st_a;
    logic [7:0] cnt_a;
    logic       ko_b, fired_b, to_b;
    logic [1:0] st_b;
    logic [7:0] cnt_b;

    always #5 clk = ~clk;

    knockout_sequencer #(
        .TRIG1_COUNT(2), .MAX_GAP(4), .KO_LEN(3), .ONESHOT(1'b1)
    ) dut_a (
        .clk(clk), .rst(rst), .en(en), .trig1(trig1), .trig2(trig2),
        .knockout(ko_a), .fired(fired_a), .timeout(to_a),
        .state(st_a), .fire_count(cnt_a)
    );

    knockout_sequencer #(
        .TRIG1_COUNT(2), .MAX_GAP(4), .KO_LEN(1), .ONESHOT(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst), .en(en), .trig1(trig1), .trig2(trig2),
        .knockout(ko_b), .fired(fired_b), .timeout(to_b),
        .state(st_b), .fire_count(cnt_b)
    );

    int p_need[2]  = '{2, 2};
    int p_gap[2]   = '{4, 4};
    int p_ko[2]    = '{3, 1};
    int p_once[2]  = '{1, 0};

    // model state: phase 0 idle, 1 armed, 2 firing, 3 done
    int m_phase[2];
    int m_seen[2];
    int m_wait[2];
    int m_left[2];
    int m_fires[2];
    bit m_fired[2];
    bit m_to[2];
    bit m_p1[2];
    bit m_p2[2];

    logic [12:0] qa[$];
    logic [12:0] qb[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic model_step(input int i, input bit r, input bit e,
                              input bit a, input bit b,
                              output logic [12:0] o);
        bit e1, e2;
        if (r) begin
            m_phase[i] = 0; m_seen[i] = 0; m_wait[i] = 0; m_left[i] = 0;
            m_fires[i] = 0; m_fired[i] = 0; m_to[i] = 0;
            m_p1[i] = 0; m_p2[i] = 0;
        end else begin
            e1 = a && !m_p1[i];
            e2 = b && !m_p2[i];
            m_p1[i] = a;
            m_p2[i] = b;
            m_to[i] = 0;
            if (m_phase[i] == 0) begin
                if (!e) m_seen[i] = 0;
                else if (e1) begin
                    m_seen[i]++;
                    if (m_seen[i] == p_need[i]) begin
                        m_phase[i] = 1; m_seen[i] = 0; m_wait[i] = 0;
                    end
                end
            end else if (m_phase[i] == 1) begin
                if (!e) begin
                    m_phase[i] = 0; m_wait[i] = 0;
                end else if (e2) begin
                    m_phase[i] = 2; m_left[i] = p_ko[i]; m_fired[i] = 1;
                    if (m_fires[i] < 255) m_fires[i]++;
                end else if (e1) begin
                    m_wait[i] = 0;
                end else if (m_wait[i] + 1 >= p_gap[i]) begin
                    m_phase[i] = 0; m_wait[i] = 0; m_to[i] = 1;
                end else begin
                    m_wait[i]++;
                end
            end else if (m_phase[i] == 2) begin
                m_left[i]--;
                if (m_left[i] == 0) m_phase[i] = (p_once[i] != 0) ? 3 : 0;
            end
        end
        o = {m_phase[i] == 2, m_fired[i], m_to[i],
             2'(m_phase[i]), 8'(m_fires[i])};
    endtask

    task automatic step(input bit r, input bit e, input bit a, input bit b);
        logic [12:0] o;
        @(negedge clk);
        rst = r; en = e; trig1 = a; trig2 = b;
        model_step(0, r, e, a, b, o);
        qa.push_back(o);
        model_step(1, r, e, a, b, o);
        qb.push_back(o);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 1, 0, 0);
    endtask

    // monitor: outputs are sampled 1 time unit after each posedge
    initial begin
        logic [12:0] exp_v, act_v;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (qa.size() > 0) begin
                exp_v = qa.pop_front();
                act_v = {ko_a, fired_a, to_a, st_a, cnt_a};
                checks++;
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL dut_a cyc=%0d ko/fired/to/state/cnt got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d",
                             cyc, act_v[12], act_v[11], act_v[10], act_v[9:8], act_v[7:0],
                             exp_v[12], exp_v[11], exp_v[10], exp_v[9:8], exp_v[7:0]);
                end
            end
            if (qb.size() > 0) begin
                exp_v = qb.pop_front();
                act_v = {ko_b, fired_b, to_b, st_b, cnt_b};
                checks++;
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL dut_b cyc=%0d ko/fired/to/state/cnt got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d",
                             cyc, act_v[12], act_v[11], act_v[10], act_v[9:8], act_v[7:0],
                             exp_v[12], exp_v[11], exp_v[10], exp_v[9:8], exp_v[7:0]);
                end
            end
        end
    end

    initial begin
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        // two trig1 pulses then trig2: fires, dut_a ends in DONE
        idle(1);
        step(0, 1, 1, 0); idle(2);
        step(0, 1, 1, 0); idle(1);
        step(0, 1, 0, 1); idle(6);
        // arm then let the window expire
        step(1, 1, 0, 0);
        step(0, 1, 1, 0); idle(2);
        step(0, 1, 1, 0); idle(8);
        // held level counts once; a later pulse arms
        step(1, 1, 0, 0);
        for (int k = 0; k < 10; k++) step(0, 1, 1, 0);
        idle(3);
        step(0, 1, 1, 0); idle(1);
        step(0, 1, 1, 0); idle(6);
        // simultaneous trig1/trig2 while armed
        step(1, 1, 0, 0);
        step(0, 1, 1, 0); idle(1);
        step(0, 1, 1, 0); idle(1);
        step(0, 1, 1, 1); idle(5);
        // trig2 on the arming cycle is ignored
        step(1, 1, 0, 0);
        step(0, 1, 1, 0); idle(1);
        step(0, 1, 1, 1); idle(6);
        // en dropped while armed, trig2 afterwards does not fire
        step(1, 1, 0, 0);
        step(0, 1, 1, 0); idle(1);
        step(0, 1, 1, 0); idle(1);
        step(0, 0, 0, 0);
        step(0, 1, 0, 1); idle(6);
        // two re-triggered sequences, reset during the second firing
        step(1, 1, 0, 0);
        for (int s = 0; s < 2; s++) begin
            step(0, 1, 1, 0); idle(1);
            step(0, 1, 1, 0); idle(1);
            step(0, 1, 0, 1);
            if (s == 0) idle(3);
        end
        step(1, 1, 0, 0); idle(3);
        // drive fire_count into saturation
        for (int s = 0; s < 262; s++) begin
            step(0, 1, 1, 0); step(0, 1, 0, 0);
            step(0, 1, 1, 0); step(0, 1, 0, 0);
            step(0, 1, 0, 1); step(0, 1, 0, 0); step(0, 1, 0, 0);
        end
        // random traffic
        for (int k = 0; k < 4000; k++)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 19) != 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain pending a=%0d b=%0d want 0", qa.size(), qb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
